mult_ctrl: RTL and testbench

Multi-cycle multiply controller for the pipelined datapath. It accepts `start_mult`/`mult_sign` from the execute stage and runs an iterative shift-add multiply, one bit per cycle. It commits the 64-bit product to the HI/LO registers and stalls the pipeline while a later instruction needs HI/LO or the multiplier. It sits beside the execute-stage ALU; its HI/LO outputs feed the `outselect` result mux.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/mult_shift_add.sv | 45 ++++
 rtl/mult_ctrl.sv | 117 +++++++++++
 tb/tb_mult_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and types shared by the execute-stage blocks
// (result-select codes, multiply controller state encoding, operand width).
package pipeline_pkg;

   localparam int MULT_W = 32;

   localparam logic [1:0] OUTSEL_ALU   = 2'b00;
   localparam logic [1:0] OUTSEL_HI    = 2'b01;
   localparam logic [1:0] OUTSEL_LO    = 2'b10;
   localparam logic [1:0] OUTSEL_SHIFT = 2'b11;

   typedef logic [1:0] mult_state_t;

   localparam mult_state_t IDLE = 2'd0;
   localparam mult_state_t BUSY = 2'd1;
   localparam mult_state_t FIX  = 2'd2;

endpackage

// File: rtl/mult_shift_add.sv
// mult_shift_add: accumulator, shifting multiplicand/multiplier and adder for the
// unsigned one-bit-per-cycle multiply; sequenced by mult_ctrl via load/step/clear.
module mult_shift_add
   import pipeline_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   input  logic                clear,
   input  logic [MULT_W-1:0]   mcand_in,
   input  logic [MULT_W-1:0]   mplier_in,
   output logic [2*MULT_W-1:0] acc,
   output logic                mplier_zero
);

   logic [2*MULT_W-1:0] mcand;
   logic [MULT_W-1:0]   mplier;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (load) begin
         acc    <= '0;
         mcand  <= {{MULT_W{1'b0}}, mcand_in};
         mplier <= mplier_in;
      end else if (clear) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (step) begin
         if (mplier[0]) begin
            acc <= acc + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

   // Once the multiplier has shifted out, acc already holds the product.
   assign mplier_zero = (mplier == '0);

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: iterative multiply controller with HI/LO commit and pipeline stall.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module mult_ctrl
   import pipeline_pkg::*;
#(
   parameter int MULT_CYCLES = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_mult,
   input  logic              mult_sign,
   input  logic [MULT_W-1:0] srca_e,
   input  logic [MULT_W-1:0] srcb_e,
   input  logic [1:0]        outselect_e,
   output logic              mult_stall,
   output logic              mult_busy,
   output logic [MULT_W-1:0] hi,
   output logic [MULT_W-1:0] lo
);

   localparam logic [4:0] CNT_LAST = 5'(MULT_CYCLES - 1);

   mult_state_t         state;
   mult_state_t         state_nxt;
   logic [4:0]          cnt;
   logic                neg;
   logic                load;
   logic                step;
   logic                clear;
   logic                last_iter;
   logic                mplier_zero;
   logic                hilo_read;
   logic [2*MULT_W-1:0] acc;
   logic [MULT_W-1:0]   mag_a;
   logic [MULT_W-1:0]   mag_b;

   // |v| for signed operands; 0x80000000 maps to 2^31, which still fits unsigned.
   function automatic logic [MULT_W-1:0] magnitude(input logic signed [MULT_W-1:0] v,
                                                   input logic sgn);
      logic signed [MULT_W-1:0] neg_v;
      neg_v = -v;
      return (sgn && (v < 0)) ? $unsigned(neg_v) : $unsigned(v);
   endfunction

   function automatic logic [2*MULT_W-1:0] apply_sign(input logic signed [2*MULT_W-1:0] p,
                                                      input logic n);
      logic signed [2*MULT_W-1:0] neg_p;
      neg_p = -p;
      return n ? $unsigned(neg_p) : $unsigned(p);
   endfunction

   assign mag_a = magnitude(srca_e, mult_sign);
   assign mag_b = magnitude(srcb_e, mult_sign);

   assign load  = (state == IDLE) && start_mult;
   assign step  = (state == BUSY) && !mplier_zero;
   assign clear = (state == FIX);

`ifdef MULT_EARLY_TERM_EN
   assign last_iter = mplier_zero || (cnt == CNT_LAST);
`else
   assign last_iter = (cnt == CNT_LAST);
`endif

   mult_shift_add u_datapath (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .step        (step),
      .clear       (clear),
      .mcand_in    (mag_a),
      .mplier_in   (mag_b),
      .acc         (acc),
      .mplier_zero (mplier_zero)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_mult) state_nxt = BUSY;
         BUSY:    if (last_iter) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         neg   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            cnt <= '0;
            neg <= mult_sign & (srca_e[MULT_W-1] ^ srcb_e[MULT_W-1]);
         end else if (state == BUSY) begin
            cnt <= cnt + 5'd1;
         end
      end
   end

   // HI/LO only move on the FIX cycle, so a same-cycle read sees the old product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (state == FIX) begin
         {hi, lo} <= apply_sign(acc, neg);
      end
   end

   assign hilo_read  = (outselect_e == OUTSEL_HI) || (outselect_e == OUTSEL_LO);
   assign mult_busy  = (state != IDLE);
   assign mult_stall = mult_busy && (start_mult || hilo_read);

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed multiply vectors; a scoreboard queue holds the expected
// product and commit latency, popped by a monitor whenever mult_busy falls.
module tb_mult_ctrl;
   import pipeline_pkg::*;

`ifdef MULT_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start_mult;
   logic        mult_sign;
   logic [31:0] srca_e;
   logic [31:0] srcb_e;
   logic [1:0]  outselect_e;
   logic        mult_stall;
   logic        mult_busy;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          start_edge;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   edge_cnt    = 0;
   int   vectors     = 0;
   int   miscompares = 0;

   mult_ctrl #(.MULT_CYCLES(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_mult  (start_mult),
      .mult_sign   (mult_sign),
      .srca_e      (srca_e),
      .srcb_e      (srcb_e),
      .outselect_e (outselect_e),
      .mult_stall  (mult_stall),
      .mult_busy   (mult_busy),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Commit latency in edges after the start edge.
   function automatic int lat_of(input logic [31:0] b, input logic sgn);
      logic [31:0] m;
      int          l;
      m = (sgn && b[31]) ? (~b + 32'd1) : b;
      l = 2;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) l = (i + 3 > 33) ? 33 : i + 3;
      end
      return EARLY ? l : 33;
   endfunction

   task automatic begin_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [31:0] eh, input logic [31:0] el,
                           input bit push);
      exp_t e;
      @(posedge clk); #1;
      srca_e     = a;
      srcb_e     = b;
      mult_sign  = sgn;
      start_mult = 1'b1;
      if (push) begin
         e.hi = eh; e.lo = el; e.start_edge = edge_cnt + 1; e.lat = lat_of(b, sgn); e.name = name;
         sb.push_back(e);
      end
   endtask

   task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [31:0] eh, input logic [31:0] el);
      begin_op(name, a, b, sgn, eh, el, 1'b1);
      @(posedge clk); #1;
      start_mult = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 80 && mult_busy; i++) @(negedge clk);
      if (mult_busy) check({name, "_idle_timeout"}, 64'd1, 64'd0);
      @(negedge clk);
   endtask

   initial begin : monitor
      bit   prev_busy;
      exp_t e;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_busy = 1'b0;
         end else begin
            if (prev_busy && !mult_busy) begin
               if (sb.size() == 0) begin
                  check("unexpected_commit", 64'd1, 64'd0);
               end else begin
                  e = sb.pop_front();
                  check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                  check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                  check({e.name, "_lat"}, 64'(edge_cnt - e.start_edge), 64'(e.lat));
               end
            end
            prev_busy = mult_busy;
         end
      end
   end

   initial begin : stim
      int   n;
      exp_t eb;
      reset       = 1'b1;
      start_mult  = 1'b0;
      mult_sign   = 1'b0;
      srca_e      = '0;
      srcb_e      = '0;
      outselect_e = OUTSEL_ALU;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hilo", {hi, lo}, 64'd0);
      check("reset_busy_stall", {62'd0, mult_busy, mult_stall}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // 3 x 5 unsigned with a dependent HI read from edge 1.
      issue("u3x5", 32'd3, 32'd5, 1'b0, 32'h0, 32'h0000000F);
      outselect_e = OUTSEL_HI;
      n = 0;
      @(negedge clk);
      for (int i = 0; i < 80 && mult_stall; i++) begin
         n++;
         @(negedge clk);
      end
      check("hi_read_stall_cycles", 64'(n), 64'(lat_of(32'd5, 1'b0) - 1 + 1));
      check("hi_read_value", {hi, lo}, 64'h0000_0000_0000_000F);
      outselect_e = OUTSEL_ALU;
      wait_idle("u3x5");

      // Signed -7 x 6, with an LO read in the start cycle returning the old value.
      outselect_e = OUTSEL_LO;
      begin_op("s_m7x6", 32'hFFFFFFF9, 32'd6, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1);
      @(negedge clk);
      check("start_cycle_no_stall", 64'(mult_stall), 64'd0);
      check("start_cycle_old_lo", 64'(lo), 64'h0000000F);
      @(posedge clk); #1;
      start_mult = 1'b0;
      @(negedge clk);
      check("busy_lo_read_stall", 64'(mult_stall), 64'd1);
      outselect_e = OUTSEL_SHIFT;
      @(negedge clk);
      check("busy_unrelated_no_stall", 64'(mult_stall), 64'd0);
      outselect_e = OUTSEL_ALU;
      wait_idle("s_m7x6");

      issue("s_min_sq", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
      wait_idle("s_min_sq");
      issue("u_min_sq", 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000);
      wait_idle("u_min_sq");
      issue("u_max_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
      wait_idle("u_max_sq");
      issue("s_m1_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001);
      wait_idle("s_m1_sq");
      issue("s_5xm3", 32'd5, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
      wait_idle("s_5xm3");
      issue("u_5x0", 32'd5, 32'd0, 1'b0, 32'h0, 32'h0);
      wait_idle("u_5x0");

      // Back-to-back: second start held from edge 1, accepted the cycle after commit.
      begin_op("b2b_a", 32'd2, 32'd3, 1'b0, 32'h0, 32'h00000006, 1'b1);
      @(posedge clk); #1;
      srca_e = 32'd7;
      srcb_e = 32'd9;
      eb.hi = 32'h0; eb.lo = 32'h0000003F; eb.name = "b2b_b";
      eb.start_edge = edge_cnt + lat_of(32'd3, 1'b0) + 1;
      eb.lat = lat_of(32'd9, 1'b0);
      sb.push_back(eb);
      n = 0;
      @(negedge clk);
      for (int i = 0; i < 80 && mult_stall; i++) begin
         n++;
         @(negedge clk);
      end
      check("b2b_stall_cycles", 64'(n), 64'(lat_of(32'd3, 1'b0)));
      @(posedge clk); #1;
      start_mult = 1'b0;
      wait_idle("b2b_b");

      // Reset in the middle of a multiply.
      begin_op("rst_mid", 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      start_mult = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      check("pre_reset_busy", 64'(mult_busy), 64'd1);
      check("pre_reset_hilo_hold", {hi, lo}, 64'h0000_0000_0000_003F);
      reset = 1'b1;
      #1;
      check("async_reset_hilo", {hi, lo}, 64'd0);
      check("async_reset_busy_stall", {62'd0, mult_busy, mult_stall}, 64'd0);
      @(posedge clk); #2;
      reset = 1'b0;
      issue("after_reset", 32'd100, 32'd200, 1'b0, 32'h0, 32'h00004E20);
      wait_idle("after_reset");

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

endmodule
